// File: rtl/pack_2x32.sv
//==============================================================================
// Module   : pack_2x32
// Function : Packs sixteen 2-bit symbols (LSB-first) into one 32-bit word with
//            a single-entry output register, flush and sticky overflow.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module pack_2x32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        valid,
    input  logic [1:0]  sr_in,
    input  logic        flush,
    input  logic        rd_ack,
    output logic        in_ready,
    output logic [31:0] data_out,
    output logic        valid_out,
    output logic        near_full,
    output logic        overflow
);

    localparam logic [3:0] c_last_sym = 4'd15;
    localparam logic [3:0] c_warn_sym = 4'd14;

    logic [29:0] r_asm;
    logic [3:0]  r_cnt;
    logic [31:0] r_data_out;
    logic        r_valid_out;
    logic        r_overflow;

    logic        w_out_blocked;
    logic        w_in_ready;
    logic        w_accept;
    logic        w_complete;
    logic        w_drop;
    logic        w_consume;
    logic [29:0] w_asm_next;

    // The last symbol can only be taken if the output slot is free or being read.
    assign w_out_blocked = (r_cnt == c_last_sym) && r_valid_out && !rd_ack;
    assign w_in_ready    = en && !flush && !w_out_blocked;
    assign w_accept      = valid && w_in_ready;
    assign w_complete    = w_accept && (r_cnt == c_last_sym);
    assign w_drop        = en && !flush && valid && !w_in_ready;
    assign w_consume     = en && rd_ack && r_valid_out;

    always_comb begin
        w_asm_next = r_asm;
        for (int k = 0; k < 15; k++) begin
            if (r_cnt == k[3:0]) begin
                w_asm_next[2*k +: 2] = sr_in;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_asm       <= '0;
            r_cnt       <= '0;
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (en) begin
            if (flush) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                if (w_complete) begin
                    r_data_out <= {sr_in, r_asm};
                    r_cnt      <= '0;
                end else begin
                    r_asm <= w_asm_next;
                    r_cnt <= r_cnt + 4'd1;
                end
            end

            // A completing word overrides a read in the same cycle.
            if (w_complete) begin
                r_valid_out <= 1'b1;
            end else if (w_consume) begin
                r_valid_out <= 1'b0;
            end

            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign data_out  = r_data_out;
    assign valid_out = r_valid_out;
    assign near_full = (r_cnt == c_warn_sym) || (r_cnt == c_last_sym);
    assign overflow  = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_pack_2x32.sv
//==============================================================================
// Module   : tb_pack_2x32
// Function : Directed bench for pack_2x32 with a word scoreboard and monitor.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_pack_2x32;

    logic        clk;
    logic        rst;
    logic        en;
    logic        valid;
    logic [1:0]  sr_in;
    logic        flush;
    logic        rd_ack;
    logic        in_ready;
    logic [31:0] data_out;
    logic        valid_out;
    logic        near_full;
    logic        overflow;

    int          total;
    int          bad;
    logic [31:0] exp_q[$];
    logic        m_prev_valid;
    logic        m_prev_consume;
    logic [31:0] w;

    pack_2x32 dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .valid     (valid),
        .sr_in     (sr_in),
        .flush     (flush),
        .rd_ack    (rd_ack),
        .in_ready  (in_ready),
        .data_out  (data_out),
        .valid_out (valid_out),
        .near_full (near_full),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic feed(input logic [31:0] word, input int lo, input int hi);
        for (int k = lo; k <= hi; k++) begin
            valid = 1'b1;
            sr_in = word[2*k +: 2];
            @(posedge clk);
            #1;
        end
        valid = 1'b0;
    endtask

    task automatic ack_one();
        rd_ack = 1'b1;
        @(posedge clk);
        #1;
        rd_ack = 1'b0;
    endtask

    // A new word is presented when valid_out rises or stays high after a read.
    always @(negedge clk) begin
        if (rst) begin
            m_prev_valid   = 1'b0;
            m_prev_consume = 1'b0;
        end else begin
            if (valid_out && (!m_prev_valid || m_prev_consume)) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected: got %h expected none", data_out);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    if (data_out !== e) begin
                        bad++;
                        $display("FAIL sb_word: got %h expected %h", data_out, e);
                    end
                end
            end
            m_prev_valid   = valid_out;
            m_prev_consume = valid_out && rd_ack && en;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total = 0; bad = 0;
        rst = 1'b1; en = 1'b0; valid = 1'b0; sr_in = 2'b00; flush = 1'b0; rd_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        en = 1'b1;
        #1;
        chk("rst_valid_out", {31'd0, valid_out}, 32'd0);
        chk("rst_data_out", data_out, 32'h0);
        chk("rst_near_full", {31'd0, near_full}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single word, near_full and one-cycle latency
        w = 32'hDEADBEEF;
        exp_q.push_back(w);
        feed(w, 0, 13);
        chk("t1_near_full_14", {31'd0, near_full}, 32'd1);
        feed(w, 14, 14);
        chk("t1_near_full_15", {31'd0, near_full}, 32'd1);
        chk("t1_no_early_valid", {31'd0, valid_out}, 32'd0);
        feed(w, 15, 15);
        chk("t1_valid_out", {31'd0, valid_out}, 32'd1);
        chk("t1_data_out", data_out, 32'hDEADBEEF);
        chk("t1_near_full_wrap", {31'd0, near_full}, 32'd0);
        ack_one();
        chk("t1_ack_clears", {31'd0, valid_out}, 32'd0);

        // Back-to-back words with rd_ack held
        rd_ack = 1'b1;
        exp_q.push_back(32'h12345678);
        exp_q.push_back(32'h9ABCDEF0);
        feed(32'h12345678, 0, 15);
        chk("t2_word0", data_out, 32'h12345678);
        chk("t2_valid0", {31'd0, valid_out}, 32'd1);
        feed(32'h9ABCDEF0, 0, 14);
        chk("t2_between", {31'd0, valid_out}, 32'd0);
        feed(32'h9ABCDEF0, 15, 15);
        chk("t2_word1", data_out, 32'h9ABCDEF0);
        chk("t2_valid1", {31'd0, valid_out}, 32'd1);
        chk("t2_overflow", {31'd0, overflow}, 32'd0);
        @(posedge clk);
        #1;
        rd_ack = 1'b0;
        chk("t2_drained", {31'd0, valid_out}, 32'd0);

        // Backpressure, overflow, and read-with-completion
        exp_q.push_back(32'h0F0F1234);
        feed(32'h0F0F1234, 0, 15);
        w = 32'h87654321;
        exp_q.push_back(w);
        feed(w, 0, 14);
        chk("t3_in_ready_low", {31'd0, in_ready}, 32'd0);
        valid = 1'b1; sr_in = 2'b01;
        @(posedge clk);
        #1;
        valid = 1'b0;
        chk("t3_overflow", {31'd0, overflow}, 32'd1);
        chk("t3_cnt_held", {31'd0, near_full}, 32'd1);
        chk("t3_still_blocked", {31'd0, in_ready}, 32'd0);
        chk("t3_data_held", data_out, 32'h0F0F1234);
        valid = 1'b1; sr_in = w[31:30]; rd_ack = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0; rd_ack = 1'b0;
        chk("t3_valid_stays", {31'd0, valid_out}, 32'd1);
        chk("t3_word2", data_out, 32'h87654321);
        ack_one();
        chk("t3_drained", {31'd0, valid_out}, 32'd0);

        // Flush discards a partial word
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("t4_overflow_rst", {31'd0, overflow}, 32'd0);
        exp_q.push_back(32'hA5A5A5A5);
        feed(32'hFFFFFFFF, 0, 6);
        flush = 1'b1; valid = 1'b1; sr_in = 2'b10;
        #1;
        chk("t4_flush_not_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0; valid = 1'b0;
        chk("t4_flush_no_ovf", {31'd0, overflow}, 32'd0);
        feed(32'hA5A5A5A5, 0, 15);
        chk("t4_word", data_out, 32'hA5A5A5A5);
        ack_one();

        // Enable low stalls everything
        w = 32'h3C3C5AA5;
        exp_q.push_back(w);
        feed(w, 0, 9);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            valid  = i[0];
            rd_ack = ~i[0];
            flush  = (i == 2);
            sr_in  = i[1:0];
            #1;
            chk("t5_in_ready_off", {31'd0, in_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        valid = 1'b0; rd_ack = 1'b0; flush = 1'b0; en = 1'b1;
        feed(w, 10, 15);
        chk("t5_valid", {31'd0, valid_out}, 32'd1);
        chk("t5_word", data_out, 32'h3C3C5AA5);
        chk("t5_overflow", {31'd0, overflow}, 32'd0);

        // Asynchronous reset mid-word with a pending output
        feed(32'hFFFFFFFF, 0, 8);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_valid_out", {31'd0, valid_out}, 32'd0);
        chk("t6_data_out", data_out, 32'h0);
        chk("t6_overflow", {31'd0, overflow}, 32'd0);
        chk("t6_near_full", {31'd0, near_full}, 32'd0);
        #3;
        rst = 1'b0;
        #1;
        chk("t6_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        exp_q.push_back(32'hC0FFEE11);
        feed(32'hC0FFEE11, 0, 15);
        chk("t6_word", data_out, 32'hC0FFEE11);
        ack_one();

        @(posedge clk);
        #1;
        chk("sb_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
